alu: RTL and testbench

//  32-bit integer ALU for the single-cycle/multicycle CPU datapath (prj1).

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_adder.sv | 29 ++
 rtl/alu.sv | 103 ++++++++++
 tb/tb_alu.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the ALUop encodings
// that the control unit drives onto the ALU.
package alu_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   localparam logic [2:0] ALUOP_AND = 3'b000;
   localparam logic [2:0] ALUOP_OR  = 3'b001;
   localparam logic [2:0] ALUOP_ADD = 3'b010;
   localparam logic [2:0] ALUOP_SUB = 3'b110;
   localparam logic [2:0] ALUOP_SLT = 3'b111;

endpackage

// File: rtl/alu_adder.sv
// Ripple-free behavioural adder with optional B inversion, shared by ADD,
// SUB and SLT. Subtraction is a + ~b + 1 with i_binv = i_cin = 1.
module alu_adder #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic                  i_binv,
   input  logic                  i_cin,
   output logic [DATA_WIDTH-1:0] o_sum,
   output logic                  o_cout,
   output logic                  o_overflow
);

   logic [DATA_WIDTH-1:0] w_b_eff;
   logic [DATA_WIDTH:0]   w_full;

   // Operand conditioning, carry-propagating add and signed-overflow detect.
   always_comb begin
      w_b_eff = i_binv ? ~i_b : i_b;
      w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{DATA_WIDTH{1'b0}}, i_cin};
      o_sum   = w_full[DATA_WIDTH-1:0];
      o_cout  = w_full[DATA_WIDTH];
      // Overflow when both addends share a sign the sum does not.
      o_overflow = (i_a[DATA_WIDTH-1] == w_b_eff[DATA_WIDTH-1]) &&
                   (w_full[DATA_WIDTH-1] != i_a[DATA_WIDTH-1]);
   end

endmodule

// File: rtl/alu.sv
// Integer ALU (AND, OR, ADD, SUB, signed SLT) with result and status flags
// registered for one cycle of latency; synchronous active-high reset.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic [2:0]            ALUop,
   output logic                  Overflow,
   output logic                  CarryOut,
   output logic                  Zero,
   output logic [DATA_WIDTH-1:0] Result
);

   logic                  w_binv;
   logic [DATA_WIDTH-1:0] w_sum;
   logic                  w_add_cout;
   logic                  w_add_ovf;
   logic [DATA_WIDTH-1:0] w_result;
   logic                  w_ovf;
   logic                  w_cout;

   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_ovf;
   logic                  r_cout;
   logic                  r_zero;

   // SUB and SLT both need A - B from the shared adder.
   always_comb begin
      w_binv = 1'b0;
      case (ALUop)
         ALUOP_SUB, ALUOP_SLT: w_binv = 1'b1;
         default:              w_binv = 1'b0;
      endcase
   end

   alu_adder #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_adder (
      .i_a        (A),
      .i_b        (B),
      .i_binv     (w_binv),
      .i_cin      (w_binv),
      .o_sum      (w_sum),
      .o_cout     (w_add_cout),
      .o_overflow (w_add_ovf)
   );

   // Operation select; unused encodings yield zero result and clear flags.
   always_comb begin
      w_result = {DATA_WIDTH{1'b0}};
      w_ovf    = 1'b0;
      w_cout   = 1'b0;
      case (ALUop)
         ALUOP_AND: w_result = A & B;
         ALUOP_OR:  w_result = A | B;
         ALUOP_ADD: begin
            w_result = w_sum;
            w_ovf    = w_add_ovf;
            w_cout   = w_add_cout;
         end
         ALUOP_SUB: begin
            w_result = w_sum;
            w_ovf    = w_add_ovf;
            // No carry out of A + ~B + 1 means A < B unsigned (a borrow).
            w_cout   = ~w_add_cout;
         end
         ALUOP_SLT: begin
            w_result = {{(DATA_WIDTH-1){1'b0}}, w_sum[DATA_WIDTH-1] ^ w_add_ovf};
         end
         default: begin
            w_result = {DATA_WIDTH{1'b0}};
            w_ovf    = 1'b0;
            w_cout   = 1'b0;
         end
      endcase
   end

   // Output register stage; Zero is registered alongside the result it describes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= {DATA_WIDTH{1'b0}};
         r_ovf    <= 1'b0;
         r_cout   <= 1'b0;
         r_zero   <= 1'b1;
      end else begin
         r_result <= w_result;
         r_ovf    <= w_ovf;
         r_cout   <= w_cout;
         r_zero   <= ~|w_result;
      end
   end

   assign Result   = r_result;
   assign Overflow = r_ovf;
   assign CarryOut = r_cout;
   assign Zero     = r_zero;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: reset, directed corner vectors and a random
// sweep compared against an arithmetic reference model.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  ALUop;
   logic        Overflow;
   logic        CarryOut;
   logic        Zero;
   logic [31:0] Result;

   int n_compared;
   int n_mismatched;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [31:0] res;
      logic        ovf;
      logic        cout;
   } vec_t;

   vec_t vecs[15];

   alu dut (
      .clk      (clk),
      .rst      (rst),
      .A        (A),
      .B        (B),
      .ALUop    (ALUop),
      .Overflow (Overflow),
      .CarryOut (CarryOut),
      .Zero     (Zero),
      .Result   (Result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Reference: signed/unsigned arithmetic on wide integers, not the adder structure.
   function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                     output logic [31:0] r, output logic o, output logic c);
      longint sa;
      longint sb;
      longint s;
      longint ua;
      longint ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      r = 32'd0;
      o = 1'b0;
      c = 1'b0;
      case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: begin
            r = a + b;
            c = (ua + ub) > 64'sd4294967295;
            s = sa + sb;
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'b110: begin
            r = a - b;
            c = ua < ub;
            s = sa - sb;
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
         default: r = 32'd0;
      endcase
   endfunction

   task automatic apply_and_check(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                  input logic [31:0] er, input logic eo, input logic ec, input string name);
      @(negedge clk);
      A = a;
      B = b;
      ALUop = op;
      @(posedge clk);
      #1;
      check($sformatf("%s res op=%b a=%h b=%h", name, op, a, b), Result, er);
      check($sformatf("%s ovf op=%b a=%h b=%h", name, op, a, b), {31'd0, Overflow}, {31'd0, eo});
      check($sformatf("%s cout op=%b a=%h b=%h", name, op, a, b), {31'd0, CarryOut}, {31'd0, ec});
      check($sformatf("%s zero op=%b a=%h b=%h", name, op, a, b), {31'd0, Zero}, {31'd0, (er == 32'd0)});
   endtask

   initial begin
      logic [2:0]  ops[5];
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rop;
      logic [31:0] er;
      logic        eo;
      logic        ec;

      n_compared   = 0;
      n_mismatched = 0;
      ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110; ops[4] = 3'b111;

      vecs[0]  = '{32'h0000_00F0, 32'h0000_003C, 3'b000, 32'h0000_0030, 1'b0, 1'b0};
      vecs[1]  = '{32'h0000_00F0, 32'h0000_003C, 3'b001, 32'h0000_00FC, 1'b0, 1'b0};
      vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b1, 1'b0};
      vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b0, 1'b1};
      vecs[4]  = '{32'h0000_0005, 32'h0000_0007, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b1};
      vecs[5]  = '{32'h0000_0007, 32'h0000_0007, 3'b110, 32'h0000_0000, 1'b0, 1'b0};
      vecs[6]  = '{32'h8000_0000, 32'h0000_0001, 3'b110, 32'h7FFF_FFFF, 1'b1, 1'b0};
      vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b0, 1'b0};
      vecs[8]  = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b111, 32'h0000_0000, 1'b0, 1'b0};
      vecs[9]  = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'h0000_0001, 1'b0, 1'b0};
      vecs[10] = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'h0000_0000, 1'b0, 1'b0};
      vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, 32'h0000_0000, 1'b0, 1'b0};
      vecs[12] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b011, 32'h0000_0000, 1'b0, 1'b0};
      vecs[13] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 32'h0000_0000, 1'b0, 1'b0};
      vecs[14] = '{32'h0000_0003, 32'h0000_0004, 3'b110, 32'hFFFF_FFFF, 1'b0, 1'b1};

      rst   = 1'b1;
      A     = 32'hFFFF_FFFF;
      B     = 32'h0000_0001;
      ALUop = 3'b010;
      @(posedge clk);
      #1;
      check("reset res", Result, 32'd0);
      check("reset ovf", {31'd0, Overflow}, 32'd0);
      check("reset cout", {31'd0, CarryOut}, 32'd0);
      check("reset zero", {31'd0, Zero}, 32'd1);

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         apply_and_check(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].ovf, vecs[i].cout, "dir");
      end

      // Reset must override an operation that would otherwise produce a nonzero result.
      apply_and_check(32'h0000_00F0, 32'h0000_000F, 3'b001, 32'h0000_00FF, 1'b0, 1'b0, "pre_rst");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_prio res", Result, 32'd0);
      check("rst_prio zero", {31'd0, Zero}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 300; i++) begin
         if (i < 200) begin
            ra = 32'($urandom_range(0, 127));
            rb = 32'($urandom_range(0, 127));
         end else begin
            ra = $urandom;
            rb = $urandom;
         end
         rop = ops[$urandom_range(0, 4)];
         if ((i % 37) == 36) rop = 3'b101;
         ref_model(ra, rb, rop, er, eo, ec);
         apply_and_check(ra, rb, rop, er, eo, ec, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
